// File: rtl/sb_issue_if.sv
// sb_issue_if: instruction offer, writeback strobe and issue result bundle for the scoreboard
interface sb_issue_if #(
  parameter int REG_BITS  = 5,
  parameter int FU_BITS   = 2,
  parameter int TYPE_BITS = 2
);
  logic                 inst_valid;
  logic                 inst_ready;
  logic [REG_BITS-1:0]  inst_fi;
  logic [TYPE_BITS-1:0] inst_fu_type;
  logic                 wb_valid;
  logic [FU_BITS-1:0]   wb_fu;
  logic                 issue_valid;
  logic [FU_BITS-1:0]   issue_fu;
  logic [REG_BITS-1:0]  issue_fi;
  modport master (
    output inst_valid, inst_fi, inst_fu_type, wb_valid, wb_fu,
    input  inst_ready, issue_valid, issue_fu, issue_fi
  );
  modport slave (
    input  inst_valid, inst_fi, inst_fu_type, wb_valid, wb_fu,
    output inst_ready, issue_valid, issue_fu, issue_fi
  );
endinterface

// File: rtl/sb_issue_ctrl.sv
// sb_issue_ctrl: scoreboard issue control with round-robin FU pick, WAW/structural hazards and stall counters
module sb_issue_ctrl #(
  parameter int NUM_FUS = 4,
  parameter int NUM_REGS = 32,
  parameter int REG_BITS = 5,
  parameter int FU_BITS = 2,
  parameter int NUM_TYPES = 4,
  parameter int TYPE_BITS = 2,
  parameter logic [NUM_TYPES*NUM_FUS-1:0] FU_TYPE_MAP = 16'b1000_0100_0011_0011,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sb_issue_if.slave          bus,
  input  logic               flush,
  output logic [NUM_FUS-1:0] fu_busy,
  output logic               waw_hazard,
  output logic               structural_hazard,
  output logic               wb_error,
  output logic [CNT_W-1:0]   struct_stall_cnt,
  output logic [CNT_W-1:0]   waw_stall_cnt
);
  logic [NUM_FUS-1:0] type_map [NUM_TYPES];
  logic [NUM_FUS-1:0] eligible, busy_n;
  logic [NUM_REGS-1:0] st_valid, st_valid_n;
  logic [NUM_REGS-1:0][FU_BITS-1:0] st_fu, st_fu_n;
  logic [FU_BITS-1:0] rr_ptr, rr_n, sel, idx;
  logic accept, wb_ok, wb_bad;
  for (genvar t = 0; t < NUM_TYPES; t++) begin : g_map
    assign type_map[t] = FU_TYPE_MAP[t*NUM_FUS +: NUM_FUS];
  end
  assign eligible = type_map[bus.inst_fu_type] & ~fu_busy;
  assign structural_hazard = bus.inst_valid & ~|eligible;
  assign waw_hazard = bus.inst_valid & (bus.inst_fi != '0) & st_valid[bus.inst_fi];
  assign accept = bus.inst_valid & ~structural_hazard & ~waw_hazard & ~flush;
  assign bus.inst_ready = accept;
  // writebacks are judged against the registered busy vector, so freed resources only appear next cycle
  assign wb_ok = bus.wb_valid & ~flush & (32'(bus.wb_fu) < NUM_FUS) & fu_busy[bus.wb_fu];
  assign wb_bad = bus.wb_valid & ~flush & ~wb_ok;
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int i = NUM_FUS - 1; i >= 0; i--) begin
      idx = FU_BITS'((32'(rr_ptr) + 32'(i)) % NUM_FUS);
      if (eligible[idx]) sel = idx;
    end
  end
  always_comb begin
    busy_n = fu_busy;
    st_valid_n = st_valid;
    st_fu_n = st_fu;
    rr_n = rr_ptr;
    if (wb_ok) begin
      busy_n[bus.wb_fu] = 1'b0;
      for (int r = 1; r < NUM_REGS; r++)
        if (st_fu[r] == bus.wb_fu) st_valid_n[r] = 1'b0;
    end
    if (accept) begin
      busy_n[sel] = 1'b1;
      rr_n = (32'(sel) == NUM_FUS - 1) ? '0 : sel + 1'b1;
      if (bus.inst_fi != '0) begin
        st_valid_n[bus.inst_fi] = 1'b1;
        st_fu_n[bus.inst_fi] = sel;
      end
    end
    if (flush) begin
      busy_n = '0;
      st_valid_n = '0;
      rr_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_busy <= '0;
      st_valid <= '0;
      st_fu <= '0;
      rr_ptr <= '0;
      bus.issue_valid <= 1'b0;
      bus.issue_fu <= '0;
      bus.issue_fi <= '0;
      wb_error <= 1'b0;
      struct_stall_cnt <= '0;
      waw_stall_cnt <= '0;
    end else begin
      fu_busy <= busy_n;
      st_valid <= st_valid_n;
      st_fu <= st_fu_n;
      rr_ptr <= rr_n;
      bus.issue_valid <= accept;
      if (accept) begin
        bus.issue_fu <= sel;
        bus.issue_fi <= bus.inst_fi;
      end
      wb_error <= wb_error | wb_bad;
      struct_stall_cnt <= struct_stall_cnt + CNT_W'(structural_hazard & ~&struct_stall_cnt);
      waw_stall_cnt <= waw_stall_cnt + CNT_W'(waw_hazard & ~structural_hazard & ~&waw_stall_cnt);
    end
  end
endmodule

// File: tb/tb_sb_issue_ctrl.sv
// tb_sb_issue_ctrl: directed and randomized checks of sb_issue_ctrl against a table-based scoreboard model
module tb_sb_issue_ctrl;
  localparam int NF = 4;
  localparam int NR = 32;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NF-1:0] fu_busy;
  logic waw_hazard, structural_hazard, wb_error;
  logic [CW-1:0] struct_stall_cnt, waw_stall_cnt;
  sb_issue_if #(.REG_BITS(5), .FU_BITS(2), .TYPE_BITS(2)) bus ();
  sb_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .fu_busy(fu_busy),
    .waw_hazard(waw_hazard), .structural_hazard(structural_hazard), .wb_error(wb_error),
    .struct_stall_cnt(struct_stall_cnt), .waw_stall_cnt(waw_stall_cnt)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int m_busy [NF];
  int m_own [NR];
  int m_rr, m_sc, m_wc, m_err, m_iv, m_ifu, m_ifi;
  logic [3:0] type_fus [4] = '{4'b0011, 4'b0011, 4'b0100, 4'b1000};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int f = 0; f < NF; f++) v[f] = (m_busy[f] != 0);
    return v;
  endfunction
  task automatic model_reset();
    for (int f = 0; f < NF; f++) m_busy[f] = 0;
    for (int r = 0; r < NR; r++) m_own[r] = -1;
    m_rr = 0; m_sc = 0; m_wc = 0; m_err = 0; m_iv = 0; m_ifu = 0; m_ifi = 0;
  endtask
  task automatic cyc(input bit v, input int fi, input int ty, input bit wv, input int wf, input bit fl);
    int sel;
    bit es, ew, er;
    bus.inst_valid = v; bus.inst_fi = 5'(fi); bus.inst_fu_type = 2'(ty);
    bus.wb_valid = wv; bus.wb_fu = 2'(wf); flush = fl;
    #1;
    sel = -1;
    for (int k = 0; k < NF; k++) begin
      int f = (m_rr + k) % NF;
      if (sel < 0 && type_fus[ty][f] && m_busy[f] == 0) sel = f;
    end
    es = v && sel < 0;
    ew = v && fi != 0 && m_own[fi] >= 0;
    er = v && !es && !ew && !fl;
    chk("inst_ready", 32'(bus.inst_ready), 32'(er));
    chk("structural_hazard", 32'(structural_hazard), 32'(es));
    chk("waw_hazard", 32'(waw_hazard), 32'(ew));
    @(posedge clk); #1;
    if (es && m_sc < 65535) m_sc++;
    if (ew && !es && m_wc < 65535) m_wc++;
    if (wv && !fl) begin
      if (wf < NF && m_busy[wf] != 0) begin
        m_busy[wf] = 0;
        for (int r = 0; r < NR; r++) if (m_own[r] == wf) m_own[r] = -1;
      end else m_err = 1;
    end
    if (er) begin
      m_busy[sel] = 1;
      if (fi != 0) m_own[fi] = sel;
      m_rr = (sel + 1) % NF;
      m_iv = 1; m_ifu = sel; m_ifi = fi;
    end else m_iv = 0;
    if (fl) begin
      for (int f = 0; f < NF; f++) m_busy[f] = 0;
      for (int r = 0; r < NR; r++) m_own[r] = -1;
      m_rr = 0;
    end
    chk("fu_busy", 32'(fu_busy), busy_vec());
    chk("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
    chk("issue_fu", 32'(bus.issue_fu), 32'(m_ifu));
    chk("issue_fi", 32'(bus.issue_fi), 32'(m_ifi));
    chk("wb_error", 32'(wb_error), 32'(m_err));
    chk("struct_stall_cnt", 32'(struct_stall_cnt), 32'(m_sc));
    chk("waw_stall_cnt", 32'(waw_stall_cnt), 32'(m_wc));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.inst_valid = 0; bus.inst_fi = 0; bus.inst_fu_type = 0; bus.wb_valid = 0; bus.wb_fu = 0;
    model_reset();
    #2;
    chk("rst_fu_busy", 32'(fu_busy), 0);
    chk("rst_issue_valid", 32'(bus.issue_valid), 0);
    chk("rst_wb_error", 32'(wb_error), 0);
    chk("rst_struct_cnt", 32'(struct_stall_cnt), 0);
    chk("rst_waw_cnt", 32'(waw_stall_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 5, 0, 0, 0, 0);
    chk("first_issue_valid", 32'(bus.issue_valid), 1);
    chk("first_issue_fu", 32'(bus.issue_fu), 0);
    chk("first_fu_busy", 32'(fu_busy), 32'b0001);
    cyc(1, 6, 0, 0, 0, 0);
    chk("second_issue_fu", 32'(bus.issue_fu), 1);
    repeat (3) cyc(1, 8, 0, 0, 0, 0);
    chk("struct_cnt_3", 32'(struct_stall_cnt), 3);
    cyc(1, 9, 2, 0, 0, 0);
    chk("r9_on_fu2", 32'(bus.issue_fu), 2);
    cyc(1, 9, 3, 0, 0, 0);
    cyc(1, 9, 3, 1, 2, 0);
    chk("waw_no_bypass_cnt", 32'(waw_stall_cnt), 2);
    cyc(1, 9, 3, 0, 0, 0);
    chk("waw_clear_fu3", 32'(bus.issue_fu), 3);
    chk("waw_clear_fi9", 32'(bus.issue_fi), 9);
    cyc(1, 0, 2, 0, 0, 0);
    chk("r0_all_busy", 32'(fu_busy), 32'b1111);
    chk("r0_no_waw_cnt", 32'(waw_stall_cnt), 2);
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 1, 3, 0);
    chk("wb_idle_error", 32'(wb_error), 1);
    chk("wb_idle_busy", 32'(fu_busy), 32'b0111);
    cyc(1, 5, 0, 0, 0, 1);
    chk("flush_busy", 32'(fu_busy), 0);
    chk("flush_keeps_error", 32'(wb_error), 1);
    cyc(1, 5, 1, 0, 0, 0);
    chk("flush_rr_zero", 32'(bus.issue_fu), 0);
    repeat (400) begin
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 29) == 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 2, 0, 0, 0);
    bus.inst_valid = 1; bus.inst_fi = 5'd3; bus.inst_fu_type = 2'd2;
    @(posedge clk); #3;
    chk("pre_reset_struct", 32'(structural_hazard), 1);
    chk("pre_reset_cnt_nonzero", 32'(struct_stall_cnt != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("async_fu_busy", 32'(fu_busy), 0);
    chk("async_issue_valid", 32'(bus.issue_valid), 0);
    chk("async_issue_fu", 32'(bus.issue_fu), 0);
    chk("async_issue_fi", 32'(bus.issue_fi), 0);
    chk("async_wb_error", 32'(wb_error), 0);
    chk("async_struct_cnt", 32'(struct_stall_cnt), 0);
    chk("async_waw_cnt", 32'(waw_stall_cnt), 0);
    chk("async_struct_flag", 32'(structural_hazard), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 4, 0, 0, 0, 0);
    chk("restart_fu0", 32'(bus.issue_fu), 0);
    cyc(1, 4, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
